// File: rtl/uart_block_assembler.sv
`default_nettype none
// ============================================================================
// Module      : uart_block_assembler
// Description : Sits behind a UART receiver and packs NUM_BYTES received bytes
//               into one wide block. The block is then offered to the AES core
//               over a valid/ready handshake. This module drives the receiver's
//               rdy_clr line, so each received byte is captured exactly once.
//               The first byte received lands in the most significant byte.
//
// Parameters  : NUM_BYTES      - bytes per block (block width 8*NUM_BYTES)
//               TIMEOUT_CYCLES - inter-byte idle limit; active only when the
//                                UART_RX_TIMEOUT_EN macro is defined
//
// Ports       : clock        in   system clock, rising edge
//               reset        in   asynchronous active-high reset
//               rdy          in   receiver byte-ready (held until cleared)
//               dout[7:0]    in   receiver byte, valid while rdy=1
//               rdy_clr      out  clear request back to the receiver
//               block_out    out  assembled block, slot 0 = MSB byte
//               block_valid  out  block_out holds a complete block
//               block_ready  in   AES core accepts the block
//               byte_count   out  bytes captured in the current block
//               timeout_err  out  1-cycle pulse when a partial block is dropped
//
// Options     : `define UART_RX_TIMEOUT_EN to discard a partial block after
//               TIMEOUT_CYCLES idle cycles. When the macro is undefined there
//               is no timeout, and timeout_err stays 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_block_assembler #(
  parameter int NUM_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               rdy,
  input  logic [7:0]                         dout,
  output logic                               rdy_clr,
  output logic [8*NUM_BYTES-1:0]             block_out,
  output logic                               block_valid,
  input  logic                               block_ready,
  output logic [$clog2(NUM_BYTES+1)-1:0]     byte_count,
  output logic                               timeout_err
);

  localparam int CW = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_CLEAR   = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t                 state_q;
  logic [8*NUM_BYTES-1:0] block_q;
  logic                   valid_q;
  logic                   rdy_clr_q;
  logic [CW-1:0]          count_q;
  logic                   timeout_err_q;
  logic [CW-1:0]          count_d;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q;
`endif

  assign count_d = count_q + CW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_COLLECT;
      block_q       <= '0;
      valid_q       <= 1'b0;
      rdy_clr_q     <= 1'b0;
      count_q       <= '0;
      timeout_err_q <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        S_COLLECT: begin
          if (rdy) begin
            // Slot i is written into byte lane NUM_BYTES-1-i, so the first
            // byte ends up in the MSB byte.
            for (int i = 0; i < NUM_BYTES; i++) begin
              if (count_q == CW'(i)) begin
                block_q[8*(NUM_BYTES-1-i) +: 8] <= dout;
              end
            end
            count_q   <= count_d;
            rdy_clr_q <= 1'b1;
            state_q   <= S_CLEAR;
`ifdef UART_RX_TIMEOUT_EN
            tmo_q     <= '0;
          end else if (count_q == '0) begin
            tmo_q <= '0;
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // Drop the partial block. Old byte contents stay in block_q and
            // are overwritten slot by slot as new bytes arrive.
            count_q       <= '0;
            tmo_q         <= '0;
            timeout_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
`endif
          end
        end

        S_CLEAR: begin
          // Hold the clear request until the receiver drops rdy. A long
          // rdy assertion therefore still produces only one capture.
          if (!rdy) begin
            rdy_clr_q <= 1'b0;
            if (count_q == CW'(NUM_BYTES)) begin
              valid_q <= 1'b1;
              state_q <= S_FULL;
            end else begin
              state_q <= S_COLLECT;
            end
          end
        end

        S_FULL: begin
          // rdy is ignored here. The receiver is backpressured until the
          // block is taken.
          if (block_ready) begin
            valid_q <= 1'b0;
            count_q <= '0;
            state_q <= S_COLLECT;
          end
        end

        default: state_q <= S_COLLECT;
      endcase
    end
  end

  assign block_out   = block_q;
  assign block_valid = valid_q;
  assign rdy_clr     = rdy_clr_q;
  assign byte_count  = count_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_block_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_block_assembler
// Description : Directed self-checking bench for uart_block_assembler. It
//               models the UART receiver side of the rdy/rdy_clr handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_block_assembler;

  localparam int NB = 16;
  localparam int TO = 100;

  logic          clock = 1'b0;
  logic          reset;
  logic          rdy;
  logic [7:0]    dout;
  logic          rdy_clr;
  logic [127:0]  block_out;
  logic          block_valid;
  logic          block_ready;
  logic [4:0]    byte_count;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  logic [127:0] last_blk = '0;

  uart_block_assembler #(
    .NUM_BYTES      (NB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rdy         (rdy),
    .dout        (dout),
    .rdy_clr     (rdy_clr),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .byte_count  (byte_count),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  // Count the cycles that see block_valid high, and keep the last block offered.
  always @(negedge clock) begin
    if (block_valid === 1'b1) begin
      vcnt++;
      last_blk = block_out;
    end
  end

  // Build a block of 16 consecutive byte values starting at base, MSB first.
  function automatic logic [127:0] seq_block(input logic [7:0] base);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < NB; i++) b[8*(NB-1-i) +: 8] = base + 8'(i);
    return b;
  endfunction

  // Receiver model: raise rdy with a byte and wait for rdy_clr. Keep rdy high
  // for hold more cycles, then drop it and let the DUT see rdy low once.
  task automatic send_byte(input logic [7:0] b, input int hold);
    int n;
    rdy  = 1'b1;
    dout = b;
    n    = 0;
    @(negedge clock);
    while (rdy_clr !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (rdy_clr !== 1'b1) begin
      bad++;
      $display("FAIL handshake_%02h: rdy_clr=%b required 1", b, rdy_clr);
    end
    repeat (hold) @(negedge clock);
    rdy = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    total++; if (block_out !== '0)   begin bad++; $display("FAIL rst_block: got %h required 0", block_out); end
    total++; if (block_valid !== 0)  begin bad++; $display("FAIL rst_valid: got %b required 0", block_valid); end
    total++; if (rdy_clr !== 0)      begin bad++; $display("FAIL rst_rdy_clr: got %b required 0", rdy_clr); end
    total++; if (byte_count !== 0)   begin bad++; $display("FAIL rst_count: got %0d required 0", byte_count); end
    total++; if (timeout_err !== 0)  begin bad++; $display("FAIL rst_tmo: got %b required 0", timeout_err); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic_block();
    int v0;
    do_reset();
    block_ready = 1'b1;
    v0 = vcnt;
    for (int i = 0; i < NB; i++) send_byte(8'(i), 1);
    repeat (3) @(negedge clock);
    total++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL basic_pulses: got %0d required 1", vcnt - v0); end
    total++; if (last_blk !== 128'h000102030405060708090A0B0C0D0E0F) begin
      bad++; $display("FAIL basic_block: got %h required 000102030405060708090a0b0c0d0e0f", last_blk);
    end
    total++; if (byte_count !== 0)  begin bad++; $display("FAIL basic_count: got %0d required 0", byte_count); end
    total++; if (block_valid !== 0) begin bad++; $display("FAIL basic_valid: got %b required 0", block_valid); end
  endtask

  task automatic test_backpressure();
    logic [127:0] snap;
    logic         unstable;
    do_reset();
    block_ready = 1'b0;
    for (int i = 0; i < NB; i++) send_byte(8'h20 + 8'(i), 1);
    total++; if (block_valid !== 1) begin bad++; $display("FAIL bp_valid: got %b required 1", block_valid); end
    total++; if (block_out !== seq_block(8'h20)) begin
      bad++; $display("FAIL bp_block: got %h required %h", block_out, seq_block(8'h20));
    end
    rdy      = 1'b1;
    dout     = 8'hAA;
    snap     = seq_block(8'h20);
    unstable = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (block_out !== snap || rdy_clr !== 1'b0 || byte_count !== 5'd16 || block_valid !== 1'b1)
        unstable = 1'b1;
    end
    total++; if (unstable !== 1'b0) begin
      bad++; $display("FAIL bp_hold: got unstable=%b (blk=%h clr=%b cnt=%0d) required 0", unstable, block_out, rdy_clr, byte_count);
    end
    block_ready = 1'b1;
    @(negedge clock);
    block_ready = 1'b0;
    total++; if (block_valid !== 0) begin bad++; $display("FAIL bp_xfer_valid: got %b required 0", block_valid); end
    total++; if (byte_count !== 0)  begin bad++; $display("FAIL bp_xfer_count: got %0d required 0", byte_count); end
    total++; if (rdy_clr !== 0)     begin bad++; $display("FAIL bp_xfer_clr: got %b required 0", rdy_clr); end
    @(negedge clock);
    total++; if (byte_count !== 1)  begin bad++; $display("FAIL bp_aa_count: got %0d required 1", byte_count); end
    total++; if (rdy_clr !== 1)     begin bad++; $display("FAIL bp_aa_clr: got %b required 1", rdy_clr); end
    total++; if (block_out !== 128'hAA2122232425262728292A2B2C2D2E2F) begin
      bad++; $display("FAIL bp_aa_block: got %h required aa2122232425262728292a2b2c2d2e2f", block_out);
    end
    rdy = 1'b0;
    @(negedge clock);
    total++; if (rdy_clr !== 0)     begin bad++; $display("FAIL bp_aa_clr_drop: got %b required 0", rdy_clr); end
  endtask

  task automatic test_long_rdy();
    int v0;
    do_reset();
    block_ready = 1'b1;
    v0 = vcnt;
    for (int i = 0; i < NB; i++) begin
      send_byte(8'h40 + 8'(i), 50);
      total++; if (byte_count !== 5'(i + 1)) begin
        bad++; $display("FAIL long_count_%0d: got %0d required %0d", i, byte_count, i + 1);
      end
    end
    repeat (3) @(negedge clock);
    total++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL long_pulses: got %0d required 1", vcnt - v0); end
    total++; if (last_blk !== seq_block(8'h40)) begin
      bad++; $display("FAIL long_block: got %h required %h", last_blk, seq_block(8'h40));
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    do_reset();
    block_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'h50 + 8'(i), 1);
    rdy  = 1'b1;
    dout = 8'h56;
    @(negedge clock);
    total++; if (rdy_clr !== 1) begin bad++; $display("FAIL mid_clr_before: got %b required 1", rdy_clr); end
    reset = 1'b1;
    #1;
    total++; if (block_out !== '0)  begin bad++; $display("FAIL mid_block: got %h required 0", block_out); end
    total++; if (block_valid !== 0) begin bad++; $display("FAIL mid_valid: got %b required 0", block_valid); end
    total++; if (rdy_clr !== 0)     begin bad++; $display("FAIL mid_clr: got %b required 0", rdy_clr); end
    total++; if (byte_count !== 0)  begin bad++; $display("FAIL mid_count: got %0d required 0", byte_count); end
    total++; if (timeout_err !== 0) begin bad++; $display("FAIL mid_tmo: got %b required 0", timeout_err); end
    rdy = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    v0 = vcnt;
    for (int i = 0; i < NB; i++) send_byte(8'h10 + 8'(i), 1);
    repeat (3) @(negedge clock);
    total++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL mid_pulses: got %0d required 1", vcnt - v0); end
    total++; if (last_blk !== seq_block(8'h10)) begin
      bad++; $display("FAIL mid_after_block: got %h required %h", last_blk, seq_block(8'h10));
    end
  endtask

  task automatic test_timeout();
    int pulses;
    int v0;
    do_reset();
    block_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'h60 + 8'(i), 1);
    pulses = 0;
    for (int c = 0; c < TO + 50; c++) begin
      @(negedge clock);
      if (timeout_err === 1'b1) pulses++;
    end
    v0 = vcnt;
`ifdef UART_RX_TIMEOUT_EN
    total++; if (pulses !== 1)     begin bad++; $display("FAIL tmo_pulses: got %0d required 1", pulses); end
    total++; if (byte_count !== 0) begin bad++; $display("FAIL tmo_count: got %0d required 0", byte_count); end
    for (int i = 0; i < NB; i++) send_byte(8'h70 + 8'(i), 1);
    repeat (3) @(negedge clock);
    total++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL tmo_after_pulses: got %0d required 1", vcnt - v0); end
    total++; if (last_blk !== seq_block(8'h70)) begin
      bad++; $display("FAIL tmo_after_block: got %h required %h", last_blk, seq_block(8'h70));
    end
`else
    total++; if (pulses !== 0)     begin bad++; $display("FAIL notmo_pulses: got %0d required 0", pulses); end
    total++; if (byte_count !== 5) begin bad++; $display("FAIL notmo_count: got %0d required 5", byte_count); end
    for (int i = 5; i < NB; i++) send_byte(8'h60 + 8'(i), 1);
    repeat (3) @(negedge clock);
    total++; if (vcnt - v0 !== 1) begin bad++; $display("FAIL notmo_after_pulses: got %0d required 1", vcnt - v0); end
    total++; if (last_blk !== seq_block(8'h60)) begin
      bad++; $display("FAIL notmo_after_block: got %h required %h", last_blk, seq_block(8'h60));
    end
`endif
  endtask

  initial begin
    reset       = 1'b1;
    rdy         = 1'b0;
    dout        = 8'h00;
    block_ready = 1'b0;
    test_reset();
    test_basic_block();
    test_backpressure();
    test_long_rdy();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
